// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a write-side FIFO, runtime baud divisor,
// 5..8 data bits, none/even/odd parity and one or two stop bits.
// Frames are sent back to back without an idle bit while the FIFO has data.
//
// Handshake: the producer pushes with wr_en; a push is accepted on a clock
// edge where wr_en=1 and full=0. A push while full is dropped and sets the
// sticky ovf flag. There is no backpressure on the serial side.
module uart_tx_fifo #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       data_bit_sel,
    input  logic [1:0]       prty_sel,
    input  logic             stop_sel,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             busy,
    output logic             bit_tick,
    output logic             data_ser
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;

    // FIFO storage and pointers
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [7:0]    rd_data;

    // Frame state
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] bit_len_q;   // clocks per bit minus one, latched at pop
    logic [DIV_W-1:0] div_m1;      // clocks per bit minus one from the live input
    logic [7:0]       sh;
    logic [2:0]       bit_idx;
    logic [2:0]       last_idx_q;
    logic             par;
    logic             par_en_q;
    logic             par_odd_q;
    logic             stop_q;
    logic             stop_idx;
    logic             last_stop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];
    assign push    = wr_en && !full;
    assign div_m1  = (div == '0) ? '0 : div - 1'b1;

    // bit_tick is registered so that it is high exactly when a non-idle bit
    // has its counter at zero; it therefore also marks the advancing edge.
    assign last_stop = (state == STOP) && bit_tick && (stop_idx == stop_q);

    // Pop decision: only from IDLE or at the close of the final stop bit
    always_comb begin
        pop = 1'b0;
        if (!empty && ((state == IDLE) || last_stop)) begin
            pop = 1'b1;
        end
    end

    // FIFO storage write, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // Transmit FSM with baud counter; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_ser   <= 1'b1;
            busy       <= 1'b0;
            bit_tick   <= 1'b0;
            baud_cnt   <= '0;
            bit_len_q  <= '0;
            sh         <= '0;
            bit_idx    <= '0;
            last_idx_q <= '0;
            par        <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop_q     <= 1'b0;
            stop_idx   <= 1'b0;
        end else begin
            // Default: count down within the current bit
            if (state != IDLE) begin
                baud_cnt <= baud_cnt - 1'b1;
                bit_tick <= (baud_cnt == DIV_W'(1));
            end

            case (state)
                IDLE: begin
                    data_ser <= 1'b1;
                    busy     <= 1'b0;
                    bit_tick <= 1'b0;
                    baud_cnt <= '0;
                end
                START: begin
                    if (bit_tick) begin
                        state    <= DATA;
                        data_ser <= sh[0];
                        par      <= sh[0];
                        sh       <= {1'b0, sh[7:1]};
                        bit_idx  <= '0;
                        baud_cnt <= bit_len_q;
                        bit_tick <= (bit_len_q == '0);
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        baud_cnt <= bit_len_q;
                        bit_tick <= (bit_len_q == '0);
                        if (bit_idx == last_idx_q) begin
                            stop_idx <= 1'b0;
                            if (par_en_q) begin
                                state    <= PARITY;
                                data_ser <= par ^ par_odd_q;
                            end else begin
                                state    <= STOP;
                                data_ser <= 1'b1;
                            end
                        end else begin
                            data_ser <= sh[0];
                            par      <= par ^ sh[0];
                            sh       <= {1'b0, sh[7:1]};
                            bit_idx  <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state    <= STOP;
                        data_ser <= 1'b1;
                        stop_idx <= 1'b0;
                        baud_cnt <= bit_len_q;
                        bit_tick <= (bit_len_q == '0);
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (stop_idx == stop_q) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            data_ser <= 1'b1;
                            bit_tick <= 1'b0;
                            baud_cnt <= '0;
                        end else begin
                            stop_idx <= 1'b1;
                            baud_cnt <= bit_len_q;
                            bit_tick <= (bit_len_q == '0);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    data_ser <= 1'b1;
                    busy     <= 1'b0;
                    bit_tick <= 1'b0;
                end
            endcase

            // A pop starts a new frame and latches the line format; it
            // overrides the IDLE return at the end of the last stop bit.
            if (pop) begin
                state      <= START;
                busy       <= 1'b1;
                data_ser   <= 1'b0;
                sh         <= rd_data;
                bit_len_q  <= div_m1;
                baud_cnt   <= div_m1;
                bit_tick   <= (div_m1 == '0);
                last_idx_q <= {1'b1, data_bit_sel};
                par_en_q   <= (prty_sel == 2'b01) || (prty_sel == 2'b10);
                par_odd_q  <= (prty_sel == 2'b10);
                stop_q     <= stop_sel;
                stop_idx   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shapes, timing, FIFO limits, reset.
module tb_uart_tx_fifo;

  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int AW         = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] div;
  logic [1:0]       data_bit_sel;
  logic [1:0]       prty_sel;
  logic             stop_sel;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             ovf;
  logic             busy;
  logic             bit_tick;
  logic             data_ser;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_fifo #(
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .div          (div),
    .data_bit_sel (data_bit_sel),
    .prty_sel     (prty_sel),
    .stop_sel     (stop_sel),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .ovf          (ovf),
    .busy         (busy),
    .bit_tick     (bit_tick),
    .data_ser     (data_ser)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic set_cfg(input logic [DIV_W-1:0] d, input logic [1:0] dbs,
                         input logic [1:0] ps, input logic ss);
    div          = d;
    data_bit_sel = dbs;
    prty_sel     = ps;
    stop_sel     = ss;
  endtask

  task automatic write_one(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Compare one whole frame cycle by cycle; exp_bits[i] is serial bit i.
  // Called at the negedge where the first start-bit cycle is visible.
  task automatic check_frame(input string tag, input logic [15:0] exp_bits,
                             input int nbits, input int d);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < d; c++) begin
        check($sformatf("%s_line_b%0d_c%0d", tag, i, c), 32'(data_ser), 32'(exp_bits[i]));
        check($sformatf("%s_busy_b%0d_c%0d", tag, i, c), 32'(busy), 32'd1);
        check($sformatf("%s_tick_b%0d_c%0d", tag, i, c), 32'(bit_tick), (c == d - 1) ? 32'd1 : 32'd0);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_line"}, 32'(data_ser), 32'd1);
    check({tag, "_idle_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    logic saw_low;
    logic saw_busy;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    set_cfg(16'd4, 2'b11, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    do_reset();

    // reset state
    check("rst_line",  32'(data_ser), 32'd1);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_tick",  32'(bit_tick), 32'd0);
    check("rst_ovf",   32'(ovf),      32'd0);
    check("rst_count", 32'(count),    32'd0);
    check("rst_empty", 32'(empty),    32'd1);
    check("rst_full",  32'(full),     32'd0);

    // div=4, 8N1, 0x2D: 0,1,0,1,1,0,1,0,0,1
    set_cfg(16'd4, 2'b11, 2'b00, 1'b0);
    write_one(8'h2D);
    check("t1_count_after_push", 32'(count), 32'd1);
    @(negedge clk);
    check_frame("t1", 16'h025A, 10, 4);
    check_idle("t1");

    // div=3, 8E1, 0x2D: parity 0; config changes mid-frame must not matter
    set_cfg(16'd3, 2'b11, 2'b01, 1'b0);
    write_one(8'h2D);
    @(negedge clk);
    set_cfg(16'd7, 2'b00, 2'b00, 1'b1);
    check_frame("t2e", 16'h045A, 11, 3);
    check_idle("t2e");

    // div=3, 8O1, 0x2D: parity 1
    set_cfg(16'd3, 2'b11, 2'b10, 1'b0);
    write_one(8'h2D);
    @(negedge clk);
    check_frame("t2o", 16'h065A, 11, 3);
    check_idle("t2o");

    // div=2, 7O2, 0xFF: 0,1111111,0,1,1
    set_cfg(16'd2, 2'b10, 2'b10, 1'b1);
    write_one(8'hFF);
    @(negedge clk);
    check_frame("t3", 16'h06FE, 11, 2);
    check_idle("t3");

    // back-to-back 0x55, 0xAA at div=2, 8N1
    set_cfg(16'd2, 2'b11, 2'b00, 1'b0);
    wr_data = 8'h55;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_data = 8'hAA;
    @(negedge clk);
    wr_en   = 1'b0;
    check("t5_count_push_pop", 32'(count), 32'd1);
    check_frame("t5a", 16'h02AA, 10, 2);
    check("t5_empty_after_pop2", 32'(empty), 32'd1);
    check("t5_count_after_pop2", 32'(count), 32'd0);
    check_frame("t5b", 16'h0354, 10, 2);
    check_idle("t5");

    // div=0 acts as div=1
    set_cfg(16'd0, 2'b11, 2'b00, 1'b0);
    write_one(8'h2D);
    @(negedge clk);
    check_frame("t6", 16'h025A, 10, 1);
    check_idle("t6");

    // div=1000, 18 consecutive writes: fill to 16, then overflow
    set_cfg(16'd1000, 2'b11, 2'b00, 1'b0);
    for (int k = 0; k < 18; k++) begin
      wr_data = 8'(k);
      wr_en   = 1'b1;
      @(negedge clk);
      if (k == 16) begin
        check("t4_full_17",  32'(full),  32'd1);
        check("t4_count_17", 32'(count), 32'd16);
        check("t4_ovf_17",   32'(ovf),   32'd0);
      end
    end
    wr_en = 1'b0;
    check("t4_ovf_18",   32'(ovf),   32'd1);
    check("t4_count_18", 32'(count), 32'd16);
    check("t4_full_18",  32'(full),  32'd1);
    check("t4_busy",     32'(busy),  32'd1);

    // reset in the middle of data bit 0 of byte 0x00 (line low)
    repeat (1200) @(negedge clk);
    check("t7_pre_line", 32'(data_ser), 32'd0);
    check("t7_pre_busy", 32'(busy),     32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_line",  32'(data_ser), 32'd1);
    check("t7_busy",  32'(busy),     32'd0);
    check("t7_count", 32'(count),    32'd0);
    check("t7_ovf",   32'(ovf),      32'd0);
    check("t7_empty", 32'(empty),    32'd1);
    check("t7_full",  32'(full),     32'd0);
    check("t7_tick",  32'(bit_tick), 32'd0);
    saw_low  = 1'b0;
    saw_busy = 1'b0;
    set_cfg(16'd1, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_ser !== 1'b1) saw_low = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    check("t7_no_frames_line", 32'(saw_low),  32'd0);
    check("t7_no_frames_busy", 32'(saw_busy), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the fixed-rate UART transmitter.
- Replaces fixed baud/format selection with:
  - a runtime clock divisor;
  - 5–8 data bits;
  - none/even/odd parity;
  - 1 or 2 stop bits.
- Adds a write-side FIFO so the producer can queue bytes. Frames are sent back-to-back without idle gaps.
- Sits between the system logic (e.g. the watch's periodic report) and the serial line feeding the receiver.

Parameters:
- DIV_W, 16, width of baud divisor (clocks per bit).
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2.
- AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- div  in  DIV_W  clocks per serial bit; 0 is treated as 1.
- data_bit_sel  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- prty_sel  in  2  00=none, 01=even, 10=odd, 11=none.
- stop_sel  in  1  0=one stop bit, 1=two stop bits.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  8  byte to send; unused upper bits ignored.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  AW+1  current FIFO occupancy.
- ovf  out  1  sticky: write attempted while full.
- busy  out  1  frame in progress.
- bit_tick  out  1  one-clock pulse at the last clock of each serial bit.
- data_ser  out  1  serial line, idle high, registered.

Behaviour:
- Reset state (cycle after rst sampled high):
  - data_ser=1, busy=0, bit_tick=0, ovf=0, count=0, empty=1, full=0.
  - FSM goes to IDLE; FIFO pointers are cleared.
  - Reset mid-frame aborts the frame; the line returns high on the next edge and queued data is discarded.
- FIFO:
  - Write when wr_en & !full.
  - wr_en & full: data dropped, ovf set; ovf clears only on rst.
  - Pop occurs only in IDLE, or at the end of the last stop bit, when !empty.
  - Simultaneous push and pop: count unchanged. A push when full is still rejected even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Config latching:
  - div, data_bit_sel, prty_sel and stop_sel are latched at pop.
  - Changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: data_ser=1. If !empty, pop into shift register and go to START.
  - START: data_ser=0 for one bit time, then DATA.
  - DATA: send LSB first, N bits (N=5..8).
    - Next state is PARITY if parity is enabled, else STOP.
  - PARITY:
    - even: bit = XOR of sent data bits.
    - odd: bit = inverse of that XOR.
    - One bit time, then STOP.
  - STOP: data_ser=1 for 1 or 2 bit times.
    - At the end: if !empty, pop and go to START in the same edge (no idle bit); otherwise go to IDLE.
- Bit timing:
  - The baud counter loads max(div,1)-1 on state entry and decrements each clock.
  - bit_tick is asserted when the counter is 0; the bit advances on that edge.
  - Each bit lasts exactly max(div,1) clocks.
- Latency: wr_en at edge N into an empty FIFO with IDLE state gives a pop at edge N+1, and data_ser=0 is visible after edge N+1.
- busy is high from START entry until the IDLE return; it stays high across back-to-back frames.
- Frame length = 1 + N + P + S bit times.

Test Plan:
- div=4, 8N1, write 0x2D:
  - data_ser sequence is 0,1,0,1,1,0,1,0,0,1, each bit exactly 4 clocks.
  - busy is high for 40 clocks; bit_tick pulses 10 times.
- div=3, 8 bits, even parity, 0x2D: parity bit=0. With odd parity: parity bit=1. Frame = 11 bits × 3 clocks.
- div=2, 7 bits, odd parity, two stop bits, 0xFF:
  - Data bits 1111111 (bit 7 not sent), parity=0, then two stop bits of 1.
  - Total 11 bits.
- div=1000, 18 consecutive writes:
  - First write popped immediately; after 17 writes full=1, count=16.
  - 18th write sets ovf=1; count is unchanged.
- Write 0x55 and 0xAA back-to-back, div=2, 8N1:
  - Second start bit immediately follows the first stop bit.
  - busy never drops; empty=1 after the second pop.
- Assert rst in the middle of the DATA state with 3 bytes queued:
  - Next cycle: data_ser=1, busy=0, count=0, ovf=0.
  - No further frames are sent.
- div=0 behaves identically to div=1 (1 clock per bit).
